// File: rtl/riscv_pkg.sv
// Shared fetch-path definitions: datapath width, default NOP encoding and
// the fetch controller state type.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry {instr, pc} holding register. It catches a response that
// arrives while the output slot is full and stalled. clear beats load,
// and load beats unload.
module fetch_skid_buf
  import riscv_pkg::*;
#(
  parameter int unsigned W = XLEN
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         unload,
  input  logic         clear,
  input  logic [W-1:0] instr_in,
  input  logic [W-1:0] pc_in,
  output logic         valid,
  output logic [W-1:0] instr,
  output logic [W-1:0] pc
);

  logic         valid_q, valid_d;
  logic [W-1:0] instr_q, instr_d;
  logic [W-1:0] pc_q, pc_d;

  // Next-state for occupancy and captured payload.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = instr_in;
      pc_d    = pc_in;
    end else if (unload) begin
      valid_d = 1'b0;
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID register. It owns the PC,
// issues one request at a time to the instruction port, and absorbs
// downstream stall and branch/jump redirect.
//
// Optional build macro FETCH_ALIGN_CHECK_EN adds output fetch_misaligned.
// A redirect to a non-word-aligned target then issues no fetch. Instead the
// stage presents a NOP tagged with the bad PC until the next redirect.
// Without the macro, the low two bits of redirect_pc are ignored.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no request; one-cycle gap after reset (or parked on misalignment)
// REQ   | request at pc outstanding; a response fills the slot or the skid
// HOLD  | response parked in the skid while the full slot is stalled
// DROP  | redirected mid-request; wait out the old response, then discard it
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned   n         = XLEN,
  parameter logic [n-1:0]  RESET_PC  = '0,
  parameter logic [n-1:0]  NOP_INSTR = n'(NOP_INSTR_DEF)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         redirect,
  input  logic [n-1:0] redirect_pc,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic [n-1:0] imem_rdata,
  output logic         fetch_valid,
  output logic [n-1:0] instruction_next,
  output logic [n-1:0] pc_next,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic         fetch_misaligned,
`endif
  output logic [n-1:0] pc_plus_four_next
);

  localparam logic [n-1:0] PC_STEP = n'(4);

  fetch_state_t state_q, state_d;
  logic [n-1:0] pc_q, pc_d;
  logic [n-1:0] drop_addr_q, drop_addr_d;
  logic         fv_q, fv_d;
  logic [n-1:0] instr_q, instr_d;
  logic [n-1:0] pcn_q, pcn_d;
  logic [n-1:0] pc4_q, pc4_d;

  logic         skid_load, skid_unload, skid_clear;
  logic         skid_valid;
  logic [n-1:0] skid_instr, skid_pc;

  logic [n-1:0] rpc_eff;
  logic         mis_now;
  logic         mis_hold;

`ifdef FETCH_ALIGN_CHECK_EN
  logic mis_q, mis_d;

  assign rpc_eff          = redirect_pc;
  assign mis_now          = redirect && (redirect_pc[1:0] != 2'b00);
  assign mis_hold         = mis_q;
  assign fetch_misaligned = mis_q;

  // Misalignment flag: set or cleared by every redirect, sticky otherwise.
  always_comb begin
    mis_d = mis_q;
    if (redirect) mis_d = mis_now;
  end

  // Misalignment flag register.
  always_ff @(posedge clk) begin
    if (reset) mis_q <= 1'b0;
    else       mis_q <= mis_d;
  end
`else
  logic unused_rpc_lsb;

  assign rpc_eff        = {redirect_pc[n-1:2], 2'b00};
  assign mis_now        = 1'b0;
  assign mis_hold       = 1'b0;
  assign unused_rpc_lsb = ^redirect_pc[1:0];
`endif

  fetch_skid_buf #(.W(n)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .load     (skid_load),
    .unload   (skid_unload),
    .clear    (skid_clear),
    .instr_in (imem_rdata),
    .pc_in    (pc_q),
    .valid    (skid_valid),
    .instr    (skid_instr),
    .pc       (skid_pc)
  );

  // Request port decodes from state only. In DROP, the address of the
  // abandoned request stays on the bus until its response arrives.
  always_comb begin
    imem_req  = (state_q == REQ) || (state_q == DROP);
    imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;
  end

  // Next-state, PC and output-slot logic. Redirect wins over everything.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    fv_d        = fv_q;
    instr_d     = instr_q;
    pcn_d       = pcn_q;
    pc4_d       = pc4_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;

    if (redirect) begin
      fv_d       = 1'b0;
      instr_d    = NOP_INSTR;
      pc_d       = rpc_eff;
      skid_clear = 1'b1;
      if (mis_now) begin
        fv_d  = 1'b1;
        pcn_d = redirect_pc;
        pc4_d = redirect_pc + PC_STEP;
      end
      case (state_q)
        REQ: begin
          drop_addr_d = pc_q;
          if (imem_ready) state_d = mis_now ? IDLE : REQ;
          else            state_d = DROP;
        end
        DROP: begin
          if (imem_ready) state_d = mis_now ? IDLE : REQ;
        end
        default: state_d = mis_now ? IDLE : REQ;
      endcase
    end else begin
      // A valid slot with no stall is taken by instr_reg this edge.
      if (fv_q && !stall && !mis_hold) fv_d = 1'b0;

      case (state_q)
        IDLE: begin
          if (!mis_hold) state_d = REQ;
        end
        REQ: begin
          if (imem_ready) begin
            if (fv_q && stall) begin
              skid_load = 1'b1;
              state_d   = HOLD;
            end else begin
              fv_d    = 1'b1;
              instr_d = imem_rdata;
              pcn_d   = pc_q;
              pc4_d   = pc_q + PC_STEP;
              pc_d    = pc_q + PC_STEP;
            end
          end
        end
        HOLD: begin
          if (!stall && skid_valid) begin
            skid_unload = 1'b1;
            fv_d        = 1'b1;
            instr_d     = skid_instr;
            pcn_d       = skid_pc;
            pc4_d       = skid_pc + PC_STEP;
            pc_d        = pc_q + PC_STEP;
            state_d     = REQ;
          end
        end
        DROP: begin
          if (imem_ready) state_d = mis_hold ? IDLE : REQ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, PC and output-slot registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      fv_q        <= 1'b0;
      instr_q     <= NOP_INSTR;
      pcn_q       <= '0;
      pc4_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      fv_q        <= fv_d;
      instr_q     <= instr_d;
      pcn_q       <= pcn_d;
      pc4_q       <= pc4_d;
    end
  end

  assign fetch_valid       = fv_q;
  assign instruction_next  = instr_q;
  assign pc_next           = pcn_q;
  assign pc_plus_four_next = pc4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run checked
// against a transaction-level model (queue of delivered instructions,
// outstanding-request bookkeeping).
module tb_fetch_stage;
  import riscv_pkg::*;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [31:0] T3_PC = 32'd252;
`else
  localparam logic [31:0] T3_PC = 32'd250;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, redirect, imem_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, fetch_valid;
  logic [31:0] imem_addr, instruction_next, pc_next, pc_plus_four_next;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  fetch_stage #(.n(32), .RESET_PC(32'h0), .NOP_INSTR(32'h13)) dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ready        (imem_ready),
    .imem_rdata        (imem_rdata),
    .fetch_valid       (fetch_valid),
    .instruction_next  (instruction_next),
    .pc_next           (pc_next),
`ifdef FETCH_ALIGN_CHECK_EN
    .fetch_misaligned  (fetch_misaligned),
`endif
    .pc_plus_four_next (pc_plus_four_next)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: instructions waiting to be delivered (slot first,
  // then at most one parked behind it) and the outstanding request.
  typedef struct { logic [31:0] instr; logic [31:0] pc; } item_t;
  item_t       mq[$];
  bit          m_req;
  bit          m_drop;
  logic [31:0] m_addr;
  logic [31:0] m_pc;

  task automatic model_reset();
    mq.delete();
    m_req  = 1'b0;
    m_drop = 1'b0;
    m_addr = 32'h0;
    m_pc   = 32'h0;
  endtask

  task automatic model_step(input bit s, input bit rd, input logic [31:0] rpc,
                            input bit rdy, input logic [31:0] data);
    bit    fire, was_live;
    item_t it;
    fire     = m_req && rdy;
    was_live = m_req;
    if (rd) begin
      mq.delete();
      m_pc = rpc & 32'hFFFF_FFFC;
      if (m_req && !rdy) m_drop = 1'b1;
      else begin
        m_drop = 1'b0;
        m_req  = 1'b1;
        m_addr = m_pc;
      end
    end else begin
      if (mq.size() > 0 && !s) void'(mq.pop_front());
      if (fire) begin
        if (m_drop) m_drop = 1'b0;
        else begin
          it.instr = data;
          it.pc    = m_addr;
          mq.push_back(it);
          m_pc = m_addr + 32'd4;
        end
      end
      if (!m_drop) begin
        m_req = (mq.size() < 2);
        if (m_req && (fire || !was_live)) m_addr = m_pc;
      end
    end
  endtask

  // One clock: compare DUT against model (at negedge), apply inputs,
  // advance model across the posedge, return at the next negedge.
  task automatic cyc(input bit s, input bit rd, input logic [31:0] rpc,
                     input bit rdy, input logic [31:0] data);
    check_eq("imem_req", imem_req, m_req);
    if (m_req) check_eq("imem_addr", imem_addr, m_addr);
    check_eq("fetch_valid", fetch_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      check_eq("instr", instruction_next, mq[0].instr);
      check_eq("pc_next", pc_next, mq[0].pc);
      check_eq("pc_plus_four", pc_plus_four_next, mq[0].pc + 32'd4);
    end
    reset       = 1'b0;
    stall       = s;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ready  = rdy;
    imem_rdata  = data;
    @(posedge clk);
    model_step(s, rd, rpc, rdy, data);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    stall      = 1'b0;
    redirect   = 1'b0;
    imem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ready = 1'b0; imem_rdata = '0;
    model_reset();

    // Reset values, and a ready strobe in IDLE must be ignored.
    do_reset();
    check_eq("rst_req", imem_req, 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_valid", fetch_valid, 32'd0);
    check_eq("rst_instr", instruction_next, 32'h13);
    check_eq("rst_pc", pc_next, 32'h0);
    check_eq("rst_pc4", pc_plus_four_next, 32'h0);
    cyc(0, 0, 0, 1, 32'hDEAD);

    // Back-to-back fetches.
    cyc(0, 0, 0, 1, 55);
    check_eq("t1_pc0", pc_next, 0);
    check_eq("t1_pc4_0", pc_plus_four_next, 4);
    cyc(0, 0, 0, 1, 56);
    check_eq("t1_pc1", pc_next, 4);
    check_eq("t1_pc4_1", pc_plus_four_next, 8);
    cyc(0, 0, 0, 1, 57);
    check_eq("t1_pc2", pc_next, 8);
    check_eq("t1_pc4_2", pc_plus_four_next, 12);

    // Response lands while the slot is full and stalled.
    cyc(1, 0, 0, 1, 55);
    check_eq("t2_req_hold", imem_req, 0);
    check_eq("t2_instr_hold", instruction_next, 57);
    cyc(1, 0, 0, 0, 0);
    check_eq("t2_instr_hold2", instruction_next, 57);
    cyc(0, 0, 0, 0, 0);
    check_eq("t2_instr", instruction_next, 55);
    check_eq("t2_pc", pc_next, 12);
    check_eq("t2_next_addr", imem_addr, 16);

    // Redirect while a request is outstanding; the late response is dropped.
    cyc(0, 1, T3_PC, 0, 0);
    check_eq("t3_valid", fetch_valid, 0);
    check_eq("t3_instr_nop", instruction_next, 32'h13);
    check_eq("t3_old_addr", imem_addr, 16);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 99);
    check_eq("t3_new_addr", imem_addr, T3_PC & 32'hFFFF_FFFC);
    check_eq("t3_valid2", fetch_valid, 0);
    cyc(0, 0, 0, 1, 100);
    check_eq("t3_instr", instruction_next, 100);
    check_eq("t3_pc", pc_next, T3_PC & 32'hFFFF_FFFC);

    // Redirect in the same cycle as a response.
    cyc(0, 1, 1444, 1, 77);
    check_eq("t4_addr", imem_addr, 1444);
    check_eq("t4_valid", fetch_valid, 0);
    cyc(0, 0, 0, 1, 32'h123);
    check_eq("t4_pc4", pc_plus_four_next, 1448);

    // PC wrap at the top of the address space.
    cyc(0, 1, 32'hFFFF_FFFC, 1, 0);
    cyc(0, 0, 0, 1, 32'hAB);
    check_eq("t5_pc", pc_next, 32'hFFFF_FFFC);
    check_eq("t5_pc4", pc_plus_four_next, 32'h0);
    check_eq("t5_addr", imem_addr, 32'h0);

    // Randomized traffic, including occasional mid-run resets.
    for (int i = 0; i < 4000; i++) begin
      bit          s, rd, rdy;
      logic [31:0] rpc;
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        check_eq("rr_req", imem_req, 0);
        check_eq("rr_valid", fetch_valid, 0);
        check_eq("rr_instr", instruction_next, 32'h13);
      end
      s   = ($urandom_range(0, 2) == 0);
      rd  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                        : ($urandom & 32'hFFFF_FFFC);
      rdy = m_req && ($urandom_range(0, 1) == 1);
      cyc(s, rd, rpc, rdy, $urandom);
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect parks a tagged NOP and stops fetching.
    do_reset();
    cyc(0, 0, 0, 0, 0);
    redirect = 1'b1; redirect_pc = 32'd250; imem_ready = 1'b1; imem_rdata = 32'h55;
    @(posedge clk); @(negedge clk);
    redirect = 1'b0; imem_ready = 1'b0;
    check_eq("al_mis", fetch_misaligned, 1);
    check_eq("al_valid", fetch_valid, 1);
    check_eq("al_instr", instruction_next, 32'h13);
    check_eq("al_pc", pc_next, 32'd250);
    for (int k = 0; k < 4; k++) begin
      stall = k[0];
      @(posedge clk); @(negedge clk);
      check_eq("al_req_off", imem_req, 0);
      check_eq("al_valid_hold", fetch_valid, 1);
    end
    stall = 1'b0; redirect = 1'b1; redirect_pc = 32'd256;
    @(posedge clk); @(negedge clk);
    redirect = 1'b0;
    check_eq("al_mis_clr", fetch_misaligned, 0);
    check_eq("al_valid_clr", fetch_valid, 0);
    check_eq("al_req_on", imem_req, 1);
    check_eq("al_addr", imem_addr, 32'd256);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
